// File: rtl/scope_capture.sv
// scope_capture: decimating edge-triggered capture buffer that
// freezes a pre/post-trigger window in a ring RAM for readout.
module scope_capture #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 8,
  parameter int PRE_TRIG     = 64,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SAMPLE,
  input  logic [15:0]       DECIM,
  input  logic [DATA_W-1:0] TRIG_LEVEL,
  input  logic              TRIG_EDGE,
  input  logic              TRIG_MODE,
  input  logic              ARM,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              TRIGGERED
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] PRE_A =
    ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_A =
    ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [TMO_W-1:0] TMO_A =
    TMO_W'(AUTO_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]       decim_q, decim_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic              edge_q, edge_d;
  logic              mode_q, mode_d;
  logic [15:0]       dcnt_q, dcnt_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              trig_q, trig_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic              busy;
  logic              tick;
  logic              hit;
  logic              fire;
  logic              we;
  logic [TMO_W-1:0]  tmo_inc;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W-1:0] rd_idx;

  always_comb begin
    state_d    = state_q;
    decim_d    = decim_q;
    level_d    = level_q;
    edge_d     = edge_q;
    mode_d     = mode_q;
    dcnt_d     = dcnt_q;
    pre_d      = pre_q;
    tmo_d      = tmo_q;
    post_d     = post_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    prev_d     = prev_q;
    trig_d     = trig_q;
    we         = 1'b0;
    fire       = 1'b0;

    busy = (state_q == S_PRE)
        || (state_q == S_WAIT)
        || (state_q == S_POST);
    tick = busy && (dcnt_q == decim_q);

    hit = edge_q
        ? (prev_q > level_q && SAMPLE <= level_q)
        : (prev_q < level_q && SAMPLE >= level_q);
    tmo_inc = tmo_q + TMO_W'(1);

    if (busy)
      dcnt_d = tick ? '0 : dcnt_q + 16'd1;

    if (tick) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      prev_d   = SAMPLE;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ARM) begin
          decim_d = DECIM;
          level_d = TRIG_LEVEL;
          edge_d  = TRIG_EDGE;
          mode_d  = TRIG_MODE;
          dcnt_d  = '0;
          pre_d   = '0;
          tmo_d   = '0;
          trig_d  = 1'b0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (tick) begin
          pre_d = pre_q + ADDR_W'(1);
          if (pre_q == PRE_A - ADDR_W'(1))
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tick) begin
          fire = hit || (mode_q && tmo_inc == TMO_A);
          // saturate so normal mode can wait forever
          if (!hit && tmo_q != '1)
            tmo_d = tmo_inc;
          if (fire) begin
            trig_ptr_d = wr_ptr_q;
            trig_d     = hit;
            post_d     = POST_A;
            state_d    = (POST_A == '0) ? S_DONE
                                        : S_POST;
          end
        end
      end
      S_POST: begin
        if (tick) begin
          post_d = post_q - ADDR_W'(1);
          if (post_q == ADDR_W'(1))
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    start_ptr = trig_ptr_q - PRE_A;
    rd_idx    = start_ptr + RD_ADDR;
    rd_data_d = ram_q[rd_idx];
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      decim_q    <= '0;
      level_q    <= '0;
      edge_q     <= 1'b0;
      mode_q     <= 1'b0;
      dcnt_q     <= '0;
      pre_q      <= '0;
      tmo_q      <= '0;
      post_q     <= '0;
      wr_ptr_q   <= '0;
      trig_ptr_q <= '0;
      prev_q     <= '0;
      trig_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      decim_q    <= decim_d;
      level_q    <= level_d;
      edge_q     <= edge_d;
      mode_q     <= mode_d;
      dcnt_q     <= dcnt_d;
      pre_q      <= pre_d;
      tmo_q      <= tmo_d;
      post_q     <= post_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      prev_q     <= prev_d;
      trig_q     <= trig_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // no reset on storage; reads see pre-write contents
  always_ff @(posedge CLOCK) begin
    if (we && !RESET)
      ram_q[wr_ptr_q] <= SAMPLE;
  end

  assign RD_DATA   = rd_data_q;
  assign BUSY      = busy;
  assign DONE      = (state_q == S_DONE);
  assign TRIGGERED = trig_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: randomized and directed capture runs checked
// against a tick-level model of the trigger window.
module tb_scope_capture;

  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int PRE   = 64;
  localparam int ATO   = 1000;
  localparam int NC    = 10600;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [DW-1:0] SAMPLE;
  logic [15:0]   DECIM;
  logic [DW-1:0] TRIG_LEVEL;
  logic          TRIG_EDGE;
  logic          TRIG_MODE;
  logic          ARM;
  logic [AW-1:0] RD_ADDR;
  logic [DW-1:0] RD_DATA;
  logic          BUSY;
  logic          DONE;
  logic          TRIGGERED;

  scope_capture #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .PRE_TRIG(PRE),
    .AUTO_TIMEOUT(ATO)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .SAMPLE(SAMPLE),
    .DECIM(DECIM),
    .TRIG_LEVEL(TRIG_LEVEL),
    .TRIG_EDGE(TRIG_EDGE),
    .TRIG_MODE(TRIG_MODE),
    .ARM(ARM),
    .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA),
    .BUSY(BUSY),
    .DONE(DONE),
    .TRIGGERED(TRIGGERED)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk;
  int n_fail;
  int val [NC+1];
  int win [DEPTH];
  int rd_obs [DEPTH];
  bit last_found;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // val[c] is SAMPLE seen at the c-th clock edge after ARM;
  // tick k (k>=0) lands on edge (k+1)*(d+1).
  task automatic run(input string tag, input int d,
                     input int lvl, input bit edg,
                     input bit mode, input int arm_at,
                     input int busy_at, input int abort_at);
    int  nt;
    int  trig;
    int  cl;
    bit  found;
    bit  forced;
    bit  aborted;
    int  p;
    int  s;
    bit  h;
    found   = 0;
    forced  = 0;
    aborted = 0;
    trig    = 0;
    cl      = 0;
    nt      = NC / (d + 1);
    for (int i = PRE; i < nt && !found; i++) begin
      p = val[i * (d + 1)];
      s = val[(i + 1) * (d + 1)];
      h = edg ? (p > lvl && s <= lvl)
              : (p < lvl && s >= lvl);
      if (h) begin
        found = 1; trig = i;
      end else if (mode && (i - PRE + 1) == ATO) begin
        found = 1; trig = i; forced = 1;
      end
    end
    if (found) begin
      cl = (trig + DEPTH - PRE) * (d + 1);
      if (cl > NC) found = 0;
    end
    if (found)
      for (int k = 0; k < DEPTH; k++)
        win[k] = val[(trig - PRE + k + 1) * (d + 1)];

    DECIM      = 16'(d);
    TRIG_LEVEL = DW'(lvl);
    TRIG_EDGE  = edg;
    TRIG_MODE  = mode;
    ARM        = 1'b1;
    @(posedge CLOCK); #1;
    ARM        = 1'b0;
    DECIM      = 16'($urandom);
    TRIG_LEVEL = DW'($urandom);
    TRIG_EDGE  = 1'($urandom);
    TRIG_MODE  = 1'($urandom);

    for (int c = 1; c <= NC; c++) begin
      SAMPLE = DW'(val[c]);
      ARM    = (c == arm_at);
      @(posedge CLOCK); #1;
      if (c == busy_at) begin
        check({tag, " busy hold"}, 32'(BUSY), 1);
        check({tag, " done hold"}, 32'(DONE), 0);
      end
      if (c == abort_at) begin
        aborted = 1;
        break;
      end
      if (found && c == cl - 1)
        check({tag, " done early"}, 32'(DONE), 0);
      if (found && c == cl) begin
        check({tag, " done"}, 32'(DONE), 1);
        check({tag, " busy off"}, 32'(BUSY), 0);
        check({tag, " triggered"},
              32'(TRIGGERED), 32'(!forced));
        break;
      end
    end
    ARM = 1'b0;

    if (aborted) begin
      RESET = 1'b1;
      @(posedge CLOCK); #1;
      check({tag, " rst busy"}, 32'(BUSY), 0);
      check({tag, " rst done"}, 32'(DONE), 0);
      check({tag, " rst trig"}, 32'(TRIGGERED), 0);
      check({tag, " rst rd"}, 32'(RD_DATA), 0);
      RESET = 1'b0;
      found = 0;
    end

    if (found)
      for (int k = 0; k < DEPTH; k++) begin
        RD_ADDR = AW'(k);
        @(posedge CLOCK); #1;
        rd_obs[k] = int'(RD_DATA);
        check($sformatf("%s rd[%0d]", tag, k),
              32'(RD_DATA), 32'(win[k]));
      end
    last_found = found;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    SAMPLE     = '0;
    DECIM      = '0;
    TRIG_LEVEL = '0;
    TRIG_EDGE  = 1'b0;
    TRIG_MODE  = 1'b0;
    ARM        = 1'b0;
    RD_ADDR    = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    check("reset busy", 32'(BUSY), 0);
    check("reset done", 32'(DONE), 0);
    check("reset trig", 32'(TRIGGERED), 0);
    check("reset rd", 32'(RD_DATA), 0);
    RESET = 1'b0;
    @(posedge CLOCK); #1;

    for (int c = 0; c <= NC; c++)
      val[c] = (16 * (c - 1)) & 'hFFF;
    run("s1", 0, 'h800, 0, 0, -1, -1, -1);
    if (last_found) begin
      check("s1 rd0", 32'(rd_obs[0]), 'h400);
      check("s1 rd64", 32'(rd_obs[64]), 'h800);
      check("s1 rd255", 32'(rd_obs[255]), 'h3F0);
    end

    for (int c = 0; c <= NC; c++)
      val[c] = ('hFFF - 16 * (c - 1)) & 'hFFF;
    run("s2", 0, 'h400, 1, 0, -1, -1, -1);
    if (last_found) begin
      check("s2 rd64", 32'(rd_obs[64]), 'h3FF);
      check("s2 rd63", 32'(rd_obs[63]), 'h40F);
    end

    for (int c = 0; c <= NC; c++)
      val[c] = (c - 1 < 10) ? 'h700 :
               (c == 10050) ? 'h700 : 'h900;
    run("s3", 0, 'h800, 0, 0, 10010, 10000, -1);

    for (int c = 0; c <= NC; c++)
      val[c] = 'h100;
    run("s4", 0, 'h800, 0, 1, -1, -1, -1);

    for (int c = 0; c <= NC; c++)
      val[c] = c & 'hFFF;
    run("s5", 3, 'h800, 0, 0, -1, -1, -1);
    if (last_found)
      for (int k = 0; k < DEPTH - 1; k++)
        check($sformatf("s5 step[%0d]", k),
              32'((rd_obs[k + 1] - rd_obs[k]) & 'hFFF), 4);

    for (int c = 0; c <= NC; c++)
      val[c] = (16 * (c - 1)) & 'hFFF;
    run("s6a", 0, 'h800, 0, 0, -1, -1, 200);
    run("s6b", 0, 'h800, 0, 0, -1, -1, -1);
    if (last_found) begin
      check("s6 rd0", 32'(rd_obs[0]), 'h400);
      check("s6 rd64", 32'(rd_obs[64]), 'h800);
    end

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c <= NC; c++)
        val[c] = int'($urandom_range(0, 4095));
      run($sformatf("rnd%0d", r),
          int'($urandom_range(0, 2)),
          int'($urandom_range(256, 3839)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
Triggered capture buffer directly downstream of the 8-channel ADC sampler. It takes one 12-bit channel word (channel mux is external), decimates it to a programmable sample rate and runs edge-trigger detection. It stores a pre-/post-trigger window in an internal ring RAM. After capture it freezes, so the display/readout logic can read the window in time order through a random-access port.

Parameters:
DATA_W, 12, sample width (matches ADC channel width)
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W samples
PRE_TRIG, 64, samples kept before trigger sample; legal range 1..DEPTH-1
AUTO_TIMEOUT, 65535, decimated ticks in WAIT_TRIG before auto mode forces a trigger

Ports:
CLOCK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
SAMPLE  in  DATA_W  current channel value from ADC block; updates asynchronously to ticks
DECIM  in  16  decimation; one sample stored every DECIM+1 clocks
TRIG_LEVEL  in  DATA_W  trigger threshold, unsigned
TRIG_EDGE  in  1  0 = rising, 1 = falling
TRIG_MODE  in  1  0 = normal (wait forever), 1 = auto (force after AUTO_TIMEOUT)
ARM  in  1  single-cycle start request
RD_ADDR  in  ADDR_W  logical read index; 0 = oldest sample of window, PRE_TRIG = trigger sample
RD_DATA  out  DATA_W  registered read data
BUSY  out  1  high in PRE, WAIT_TRIG, POST
DONE  out  1  high in DONE state; window valid
TRIGGERED  out  1  1 = real edge trigger, 0 = forced by auto timeout; valid when DONE=1

Behaviour:
- Reset: state IDLE; BUSY=0, DONE=0, TRIGGERED=0, RD_DATA=0, wr_ptr=0, decim counter=0, tick counters=0. RAM contents are not cleared. Reset mid-capture aborts to IDLE immediately.
- ARM is accepted only in IDLE or DONE and is ignored while BUSY. On acceptance:
  - latch DECIM, TRIG_LEVEL, TRIG_EDGE, TRIG_MODE;
  - clear decim counter, pre counter, timeout counter, TRIGGERED;
  - DONE<=0; next state PRE.
- Tick: the decim counter runs in PRE/WAIT_TRIG/POST. Tick fires when counter==DECIM_latched, and the counter then reloads 0. With DECIM=0 there is a tick every clock. The first tick occurs DECIM_latched+1 clocks after the ARM cycle.
- On every tick in PRE/WAIT_TRIG/POST: RAM[wr_ptr]<=SAMPLE; wr_ptr<=wr_ptr+1 mod DEPTH (wraps); prev<=SAMPLE.
- PRE: count ticks. On the PRE_TRIG-th tick go to WAIT_TRIG. Trigger conditions are ignored in PRE.
- WAIT_TRIG, evaluated only on ticks, using the current tick's SAMPLE against prev:
  - rising: prev < TRIG_LEVEL and SAMPLE >= TRIG_LEVEL;
  - falling: prev > TRIG_LEVEL and SAMPLE <= TRIG_LEVEL.
  - On a hit: trig_ptr<=wr_ptr (address of the sample written this tick); TRIGGERED<=1; post counter<=DEPTH-PRE_TRIG-1; go to POST (or straight to DONE if that count is 0).
  - Auto mode: the timeout counter increments per non-triggering tick. On the tick where it reaches AUTO_TIMEOUT, that tick is treated as the trigger with TRIGGERED=0.
  - Normal mode never times out.
- POST: each tick writes and decrements the post counter. The state goes to DONE the clock after the final write; DONE and BUSY update in the same clock.
- Window: start_ptr = trig_ptr - PRE_TRIG mod DEPTH. The last write lands at start_ptr-1 mod DEPTH, so exactly DEPTH samples form a contiguous, time-ordered window.
- Read: RD_DATA <= RAM[(start_ptr + RD_ADDR) mod DEPTH], one-cycle latency, in every state. Contents are meaningful only when DONE=1. start_ptr holds its value until the next trigger.
- Simultaneous write and read of the same address outside DONE: read returns old data (read-before-write).
- Trigger compare is unsigned full-width. No arithmetic overflow elsewhere; all pointer math is mod DEPTH.

Test Plan:
1. Reset, then DECIM=0, PRE_TRIG=64, rising, level 0x800. SAMPLE = 16*n mod 4096 starting at 0 on the first tick. Required: trigger at n=128; DONE after 191 more ticks; TRIGGERED=1; RD_ADDR 0 -> 0x400, 64 -> 0x800, 255 -> 0x3F0 (one-cycle latency).
2. Falling edge, level 0x400, descending ramp 0xFFF-16n. Required: trigger at first sample <= 0x400 (n=192, 0x3FF); RD_ADDR 64 -> 0x3FF; RD_ADDR 63 -> 0x40F.
3. Crossing inside PRE: ramp crosses level at n=10 with PRE_TRIG=64, then SAMPLE held constant. Normal mode: BUSY stays 1 and DONE stays 0 for 10000 clocks. A subsequent ARM is ignored.
4. Auto mode, AUTO_TIMEOUT=1000, SAMPLE constant 0x100. Required: DONE with TRIGGERED=0; all 256 reads return 0x100.
5. DECIM=3, ramp +1 per clock. Required: stored samples differ by 4; RD_ADDR k+1 minus RD_ADDR k = 4 across the whole window, including the wr_ptr wrap.
6. RESET pulsed during POST. Required: next clock IDLE, BUSY=0, DONE=0, RD_DATA=0. A fresh ARM then completes a normal capture as in scenario 1.
